// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls, branch and
// jump flushes, and the EX/MEM forwarding-select codes registered into ID/EX.
module hazard_ctrl #(
    parameter int BR_PENALTY  = 2,
    parameter int JMP_PENALTY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_id,
    input  logic        id_valid,
    input  logic        br_taken,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [2:0]  rs_fwd,
    output logic [2:0]  rt_fwd,
    output logic [1:0]  state
);

    localparam logic [5:0] OP_JUMP = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_LDW  = 6'h23;
    localparam logic [5:0] OP_SDW  = 6'h2B;

    localparam logic [2:0] FWD_RF  = 3'd0;
    localparam logic [2:0] FWD_EX  = 3'd1;
    localparam logic [2:0] FWD_MEM = 3'd2;

    // cnt holds the number of FLUSH cycles still to run after the current one.
    localparam logic [1:0] BR_CNT  = 2'(BR_PENALTY - 1);
    localparam logic [1:0] JMP_CNT = (JMP_PENALTY > 1) ? 2'(JMP_PENALTY - 2) : 2'd0;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_LSTALL = 2'd1,
        S_FLUSH  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [4:0]  ex_dst_q, ex_dst_d;
    logic        ex_ld_q, ex_ld_d;
    logic [4:0]  mem_dst_q;
    logic [2:0]  rs_fwd_q, rs_fwd_d;
    logic [2:0]  rt_fwd_q, rt_fwd_d;

    logic [5:0]  opcode;
    logic        is_ldw, is_sdw, is_beq, is_jump;
    logic [4:0]  rs_f, rt_f, dst_f;
    logic        rs_use, rt_use;
    logic        load_use, jump_id;
    logic [2:0]  rs_code, rt_code;
    logic        unused_bits;

    assign unused_bits = ^instr_id[10:0];

    // Field decode of the instruction sitting in IF/ID.
    always_comb begin
        opcode  = instr_id[31:26];
        is_ldw  = (opcode == OP_LDW);
        is_sdw  = (opcode == OP_SDW);
        is_beq  = (opcode == OP_BEQ);
        is_jump = (opcode == OP_JUMP);
        rs_f    = instr_id[20:16];
        rt_f    = (is_sdw || is_beq || is_ldw) ? instr_id[25:21] : instr_id[15:11];
        dst_f   = (!id_valid || is_sdw || is_beq || is_jump) ? 5'd0 : instr_id[25:21];
        rs_use  = id_valid && !is_jump && (rs_f != 5'd0);
        rt_use  = id_valid && !is_jump && (rt_f != 5'd0);
        jump_id = id_valid && is_jump;
    end

    always_comb begin
        load_use = ex_ld_q && (ex_dst_q != 5'd0) &&
                   ((rs_use && (rs_f == ex_dst_q)) || (rt_use && (rt_f == ex_dst_q)));
    end

    // EX result wins over MEM when both hold the same register.
    always_comb begin
        rs_code = FWD_RF;
        if (rs_use && (rs_f == ex_dst_q) && !ex_ld_q) begin
            rs_code = FWD_EX;
        end else if (rs_use && (rs_f == mem_dst_q) && (mem_dst_q != 5'd0)) begin
            rs_code = FWD_MEM;
        end
        rt_code = FWD_RF;
        if (rt_use && (rt_f == ex_dst_q) && !ex_ld_q) begin
            rt_code = FWD_EX;
        end else if (rt_use && (rt_f == mem_dst_q) && (mem_dst_q != 5'd0)) begin
            rt_code = FWD_MEM;
        end
    end

    // State register and pipeline tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RUN;
            cnt_q     <= 2'd0;
            ex_dst_q  <= 5'd0;
            ex_ld_q   <= 1'b0;
            mem_dst_q <= 5'd0;
            rs_fwd_q  <= FWD_RF;
            rt_fwd_q  <= FWD_RF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_dst_q  <= ex_dst_d;
            ex_ld_q   <= ex_ld_d;
            mem_dst_q <= ex_dst_q;
            rs_fwd_q  <= rs_fwd_d;
            rt_fwd_q  <= rt_fwd_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_RUN: begin
                if (br_taken) begin
                    state_d = S_FLUSH;
                    cnt_d   = BR_CNT;
                end else if (load_use) begin
                    state_d = S_LSTALL;
                end else if (jump_id && (JMP_PENALTY > 1)) begin
                    state_d = S_FLUSH;
                    cnt_d   = JMP_CNT;
                end
            end
            S_LSTALL: begin
                if (br_taken) begin
                    state_d = S_FLUSH;
                    cnt_d   = BR_CNT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (br_taken) begin
                    cnt_d = BR_CNT;
                end else if (cnt_q == 2'd0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Output logic; everything is forced quiet while reset is held.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_RUN: begin
                    if (br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (jump_id) begin
                        ifid_flush  = 1'b1;
                    end
                end
                S_LSTALL: begin
                    if (br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                S_FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                default: begin
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    // A bubble enters ID/EX as a NOP: no destination, no forwarding.
    always_comb begin
        ex_dst_d = idex_bubble ? 5'd0 : dst_f;
        ex_ld_d  = !idex_bubble && id_valid && is_ldw;
        rs_fwd_d = idex_bubble ? FWD_RF : rs_code;
        rt_fwd_d = idex_bubble ? FWD_RF : rt_code;
    end

    assign rs_fwd = rs_fwd_q;
    assign rt_fwd = rt_fwd_q;
    assign state  = state_q;

endmodule
